// File: rtl/parity_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// parity_sweep_ctrl
//
// Self-test / characterisation sequencer for a 4-input combinational parity
// block. A start pulse launches a sweep over all 16 input codes in ascending
// order. Each code is held for SETTLE+1 cycles: SETTLE cycles of settling,
// then one cycle in which the block's output is captured. The captured truth
// table and its population count are kept, and a registered pass flag compares
// the table against EXP_TABLE once the sweep completes.
//
// Parameters:
//   SETTLE    - settle cycles per code before sampling (legal range 1..15)
//   EXP_TABLE - expected truth table, bit k = expected output for code k
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_start  in   one-cycle start request, honoured only when idle
//   in_abort  in   cancels a sweep in progress (no done pulse)
//   in_sum    in   out_sum of the parity block under test
//   out_a..d  out  code bits 3..0 driving in_a..in_d of the parity block
//   out_busy  out  high whenever a sweep is in progress (any state but IDLE)
//   out_done  out  one-cycle pulse at sweep completion
//   out_table out  captured truth table, bit k = in_sum sampled for code k
//   out_ones  out  number of ones in out_table (0..16)
//   out_pass  out  registered (out_table == EXP_TABLE), valid after out_done
// -----------------------------------------------------------------------------
module parity_sweep_ctrl #(
    parameter int unsigned SETTLE    = 1,
    parameter logic [15:0] EXP_TABLE = 16'h6996
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_start,
    input  logic        in_abort,
    input  logic        in_sum,
    output logic        out_a,
    output logic        out_b,
    output logic        out_c,
    output logic        out_d,
    output logic        out_busy,
    output logic        out_done,
    output logic [15:0] out_table,
    output logic [4:0]  out_ones,
    output logic        out_pass
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Settle counter reload: counts SETTLE-1 down to 0, giving SETTLE cycles
    // in S_SETTLE before the single S_SAMPLE cycle.
    localparam logic [3:0] SCNT_INIT = 4'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q,   idx_d;
    logic [3:0]  scnt_q,  scnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  ones_q,  ones_d;
    logic        pass_q,  pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        table_d = table_q;
        ones_d  = ones_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                // Abort has no meaning here, so start always wins.
                if (in_start) begin
                    idx_d   = 4'd0;
                    table_d = 16'h0000;
                    ones_d  = 5'd0;
                    pass_d  = 1'b0;
                    scnt_d  = SCNT_INIT;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (in_abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (scnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    scnt_d = scnt_q - 4'd1;
                end
            end

            S_SAMPLE: begin
                // An abort landing on the sample cycle suppresses the write,
                // leaving only codes captured before it in the table.
                if (in_abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    table_d[idx_q] = in_sum;
                    // At most 16 increments per sweep, so 5 bits never wrap.
                    ones_d = ones_q + {4'd0, in_sum};
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        scnt_d  = SCNT_INIT;
                        state_d = S_SETTLE;
                    end
                end
            end

            S_DONE: begin
                // The last sample was written on the edge entering DONE, so
                // table_q is complete here.
                pass_d  = (table_q == EXP_TABLE);
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            scnt_q  <= 4'd0;
            table_q <= 16'h0000;
            ones_q  <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
        end
    end

    // Code outputs come straight from the idx register, so the parity block
    // sees glitch-free inputs that change only on clock edges.
    assign out_a     = idx_q[3];
    assign out_b     = idx_q[2];
    assign out_c     = idx_q[1];
    assign out_d     = idx_q[0];
    assign out_busy  = (state_q != S_IDLE);
    assign out_done  = (state_q == S_DONE);
    assign out_table = table_q;
    assign out_ones  = ones_q;
    assign out_pass  = pass_q;

endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_sweep_ctrl
//
// Bench for parity_sweep_ctrl. Two instances run side by side: one with
// SETTLE=1 and one with SETTLE=3. Each instance's in_sum is produced by a
// behavioural "parity block" that looks up the current code in a truth table
// chosen per sweep (ideal parity, stuck-at-1 or random). Expected results are
// derived from the sweep timing rules: code k is held for SETTLE+1 cycles, is
// captured at the end of cycle (k+1)*(SETTLE+1) after start, and done appears
// in cycle 16*(SETTLE+1)+1.
// -----------------------------------------------------------------------------
module tb_parity_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       start;
    logic [1:0]       abort;
    logic [1:0][15:0] mtbl;

    wire  [1:0][3:0]  abcd;
    wire  [1:0]       busy;
    wire  [1:0]       done;
    wire  [1:0]       pass;
    wire  [1:0]       sum;
    wire  [1:0][15:0] tbl_o;
    wire  [1:0][4:0]  ones_o;

    // Behavioural parity blocks under control of each sequencer.
    assign sum[0] = mtbl[0][abcd[0]];
    assign sum[1] = mtbl[1][abcd[1]];

    parity_sweep_ctrl #(.SETTLE(1), .EXP_TABLE(16'h6996)) u_dut_s1 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_start  (start[0]),
        .in_abort  (abort[0]),
        .in_sum    (sum[0]),
        .out_a     (abcd[0][3]),
        .out_b     (abcd[0][2]),
        .out_c     (abcd[0][1]),
        .out_d     (abcd[0][0]),
        .out_busy  (busy[0]),
        .out_done  (done[0]),
        .out_table (tbl_o[0]),
        .out_ones  (ones_o[0]),
        .out_pass  (pass[0])
    );

    parity_sweep_ctrl #(.SETTLE(3), .EXP_TABLE(16'h6996)) u_dut_s3 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_start  (start[1]),
        .in_abort  (abort[1]),
        .in_sum    (sum[1]),
        .out_a     (abcd[1][3]),
        .out_b     (abcd[1][2]),
        .out_c     (abcd[1][1]),
        .out_d     (abcd[1][0]),
        .out_busy  (busy[1]),
        .out_done  (done[1]),
        .out_table (tbl_o[1]),
        .out_ones  (ones_o[1]),
        .out_pass  (pass[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_idle_zero(input int d, input string tag);
        check($sformatf("%s_abcd_d%0d", tag, d), 32'(abcd[d]),   32'd0);
        check($sformatf("%s_busy_d%0d", tag, d), 32'(busy[d]),   32'd0);
        check($sformatf("%s_done_d%0d", tag, d), 32'(done[d]),   32'd0);
        check($sformatf("%s_tbl_d%0d",  tag, d), 32'(tbl_o[d]),  32'd0);
        check($sformatf("%s_ones_d%0d", tag, d), 32'(ones_o[d]), 32'd0);
        check($sformatf("%s_pass_d%0d", tag, d), 32'(pass[d]),   32'd0);
    endtask

    // One sweep on instance d with parity-block truth table t.
    // abort_at / start2_at / rst_at: cycle (1-based after the start edge) in
    // which that input is held high; 0 means never.
    task automatic run_sweep(input int d, input logic [15:0] t, input int abort_at,
                             input int start2_at, input int rst_at, input bit abort_with_start);
        int          s;
        int          dn;
        int          code;
        logic [15:0] part;
        s  = settle_of(d);
        dn = 16 * (s + 1) + 1;
        mtbl[d]  = t;
        start[d] = 1'b1;
        abort[d] = abort_with_start;
        @(posedge clk); #1;
        start[d] = 1'b0;
        abort[d] = 1'b0;
        for (int n = 1; n <= dn + 1; n++) begin
            if (abort_at > 0 && n == abort_at + 1) begin
                part = '0;
                for (int k = 0; k < 16; k++)
                    if ((k + 1) * (s + 1) < abort_at) part[k] = t[k];
                check($sformatf("abort_busy_d%0d_c%0d", d, n), 32'(busy[d]),   32'd0);
                check($sformatf("abort_done_d%0d_c%0d", d, n), 32'(done[d]),   32'd0);
                check($sformatf("abort_pass_d%0d_c%0d", d, n), 32'(pass[d]),   32'd0);
                check($sformatf("abort_tbl_d%0d_c%0d",  d, n), 32'(tbl_o[d]),  32'(part));
                check($sformatf("abort_ones_d%0d_c%0d", d, n), 32'(ones_o[d]), 32'($countones(part)));
                check($sformatf("abort_abcd_d%0d_c%0d", d, n), 32'(abcd[d]),   32'((abort_at - 1) / (s + 1)));
                break;
            end
            if (rst_at > 0 && n == rst_at + 1) begin
                check_idle_zero(d, $sformatf("midrst_c%0d", n));
                break;
            end
            if (n == 1) begin
                check($sformatf("clr_tbl_d%0d",  d), 32'(tbl_o[d]),  32'd0);
                check($sformatf("clr_ones_d%0d", d), 32'(ones_o[d]), 32'd0);
                check($sformatf("clr_pass_d%0d", d), 32'(pass[d]),   32'd0);
            end
            if (n <= dn) begin
                code = (n - 1) / (s + 1);
                if (code > 15) code = 15;
                check($sformatf("busy_d%0d_c%0d", d, n), 32'(busy[d]), 32'd1);
                check($sformatf("abcd_d%0d_c%0d", d, n), 32'(abcd[d]), 32'(code));
            end
            check($sformatf("done_d%0d_c%0d", d, n), 32'(done[d]), (n == dn) ? 32'd1 : 32'd0);
            if (n == dn) begin
                check($sformatf("tbl_d%0d",  d), 32'(tbl_o[d]),  32'(t));
                check($sformatf("ones_d%0d", d), 32'(ones_o[d]), 32'($countones(t)));
            end
            if (n == dn + 1) begin
                check($sformatf("idle_busy_d%0d", d), 32'(busy[d]), 32'd0);
                check($sformatf("pass_d%0d",      d), 32'(pass[d]), (t == 16'h6996) ? 32'd1 : 32'd0);
            end
            abort[d] = (n == abort_at);
            start[d] = (n == start2_at);
            rst[d]   = (n == rst_at);
            @(posedge clk); #1;
            abort[d] = 1'b0;
            start[d] = 1'b0;
            rst[d]   = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int s;
        int ab;
        int st2;
        logic [15:0] t;

        rst   = 2'b11;
        start = 2'b00;
        abort = 2'b00;
        mtbl  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        check_idle_zero(0, "reset");
        check_idle_zero(1, "reset");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("idle_busy0_c%0d", c), 32'(busy[0]), 32'd0);
            check($sformatf("idle_abcd0_c%0d", c), 32'(abcd[0]), 32'd0);
            check($sformatf("idle_busy1_c%0d", c), 32'(busy[1]), 32'd0);
            check($sformatf("idle_abcd1_c%0d", c), 32'(abcd[1]), 32'd0);
        end

        // Ideal parity, then stuck-at-1, on SETTLE=1.
        run_sweep(0, 16'h6996, 0, 0, 0, 1'b0);
        run_sweep(0, 16'hFFFF, 0, 0, 0, 1'b0);
        // Abort in cycle 10, then restart with results cleared.
        run_sweep(0, 16'h6996, 10, 0, 0, 1'b0);
        // Second start while busy is ignored; fresh sweep afterwards.
        run_sweep(0, 16'h6996, 0, 5, 0, 1'b0);
        run_sweep(0, 16'h0000, 0, 0, 0, 1'b0);
        // Start and abort together while idle: start wins.
        run_sweep(0, 16'h6996, 0, 0, 0, 1'b1);
        // SETTLE=3 full sweep, then reset in cycle 20.
        run_sweep(1, 16'h6996, 0, 0, 0, 1'b0);
        run_sweep(1, 16'h6996, 0, 0, 20, 1'b0);
        run_sweep(1, 16'hA5C3, 0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d   = int'($urandom_range(0, 1));
            s   = settle_of(d);
            t   = 16'($urandom);
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16 * (s + 1))) : 0;
            st2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16 * (s + 1))) : 0;
            run_sweep(d, t, ab, st2, 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
